// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage responder: op encodings, FSM states and
// small op-class helpers used by both the top and the lane aligner.
package mem_access_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        LB      = 4'd1,
        LH      = 4'd2,
        LW      = 4'd3,
        LBU     = 4'd4,
        LHU     = 4'd5,
        SB      = 4'd6,
        SH      = 4'd7,
        SW      = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, replicated store data, load
// extraction with sign/zero extension, and the alignment check.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        case (op)
            LB, LBU, SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            LH, LHU, SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            LW, SW: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
        case (op)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'h0, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'h0, half_sel};
            LW:      load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage responder: runs one req/ack bus transaction per load/store,
// stalls upstream while it is outstanding and forwards the result to mem/wb.
//
// state | meaning
// IDLE  | pass-through of non-memory ops; accept aligned memory op
// REQ   | bus_req_o held with captured address/be/data until ack or timeout
// DONE  | one cycle: present load result or timeout error, release stall
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg_wdata_i,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic [31:0] load_q;
    logic        err_q;
    logic [7:0]  cnt_q;

    logic [3:0]  align_op;
    logic [1:0]  align_addr;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;
    logic        mis_c;
    logic        mem_op_c;
    logic        accept_c;

    // The aligner sees the live request in IDLE and the captured one afterwards.
    assign align_op   = (state == IDLE) ? mem_op_i : op_q;
    assign align_addr = (state == IDLE) ? mem_addr_i[1:0] : addr_q[1:0];

    mem_lane_align u_align (
        .op         (align_op),
        .addr_lo    (align_addr),
        .store_data (mem_data_i),
        .rdata      (bus_rdata_i),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_c),
        .misaligned (mis_c)
    );

    assign mem_op_c = is_mem_op(mem_op_i);
    assign accept_c = (state == IDLE) && mem_op_c && !mis_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            waddr_q <= 5'h0;
            we_q    <= 1'b0;
            load_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        op_q    <= mem_op_i;
                        addr_q  <= mem_addr_i;
                        be_q    <= be_c;
                        wdata_q <= wdata_c;
                        waddr_q <= reg_waddr_i;
                        we_q    <= mem_we_i | is_store(mem_op_i);
                        load_q  <= 32'h0;
                        err_q   <= 1'b0;
                        cnt_q   <= 8'h0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Ack wins over a simultaneous timeout.
                    if (bus_ack_i) begin
                        load_q <= load_c;
                        state  <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_we_o    = 1'b0;
        reg_waddr_o = 5'h0;
        reg_wdata_o = 32'h0;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'h0;
        bus_be_o    = 4'h0;
        bus_wdata_o = 32'h0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    reg_waddr_o = reg_waddr_i;
                    reg_wdata_o = reg_wdata_i;
                    if (!mem_op_c)
                        reg_we_o = reg_we_i;
                    else if (mis_c)
                        misalign_o = 1'b1;
                    else
                        stall_o = 1'b1;
                end
                REQ: begin
                    stall_o     = 1'b1;
                    bus_req_o   = 1'b1;
                    bus_we_o    = we_q;
                    bus_addr_o  = {addr_q[31:2], 2'b00};
                    bus_be_o    = be_q;
                    bus_wdata_o = wdata_q;
                end
                DONE: begin
                    reg_we_o    = !is_store(op_q) && !err_q;
                    reg_waddr_o = waddr_q;
                    reg_wdata_o = load_q;
                    bus_err_o   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected bus/writeback
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int unsigned TO = 4;
    localparam int EV_BUS  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_MIS  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_data = 32'h0;
    logic [3:0]  mem_op = 4'h0;
    logic        reg_we_in = 1'b0;
    logic [4:0]  reg_waddr_in = 5'h0;
    logic [31:0] reg_wdata_in = 32'h0;
    logic        reg_we_out;
    logic [4:0]  reg_waddr_out;
    logic [31:0] reg_wdata_out;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_op_i(mem_op),
        .reg_we_i(reg_we_in), .reg_waddr_i(reg_waddr_in), .reg_wdata_i(reg_wdata_in),
        .reg_we_o(reg_we_out), .reg_waddr_o(reg_waddr_out), .reg_wdata_o(reg_wdata_out),
        .stall_o(stall), .misalign_o(misalign), .bus_err_o(bus_err),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        reg_we;
        logic [4:0]  waddr;
        logic [31:0] rdata;
        logic        err;
        int          req_cycles;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_ev(input int kind, input string name, output ev_t e, output bit ok);
        checks++;
        ok = 1'b0;
        e = '{default: 0};
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: event kind %0d seen, nothing expected", name, kind);
        end else if (exp_q[0].kind != kind) begin
            failures++;
            $display("FAIL %s: event kind %0d seen, expected kind %0d", name, kind, exp_q[0].kind);
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Monitor
    logic prev_req = 1'b0;
    int   req_cnt = 0;
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus_req && !prev_req) begin
                req_cnt = 0;
                pop_ev(EV_BUS, "bus_event", e, ok);
                if (ok) begin
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_be", {28'h0, bus_be}, {28'h0, e.be});
                    chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
                    chk("bus_wdata", bus_wdata, e.wdata);
                end
            end
            if (bus_req) req_cnt++;
            if (prev_req && !bus_req) begin
                pop_ev(EV_DONE, "done_event", e, ok);
                if (ok) begin
                    chk("done_reg_we", {31'h0, reg_we_out}, {31'h0, e.reg_we});
                    chk("done_bus_err", {31'h0, bus_err}, {31'h0, e.err});
                    chk("done_stall", {31'h0, stall}, 32'h0);
                    chk("done_req_cycles", req_cnt, e.req_cycles);
                    if (e.reg_we) begin
                        chk("done_waddr", {27'h0, reg_waddr_out}, {27'h0, e.waddr});
                        chk("done_wdata", reg_wdata_out, e.rdata);
                    end
                end
            end
            if (misalign) begin
                pop_ev(EV_MIS, "misalign_event", e, ok);
                if (ok) chk("mis_req", {31'h0, bus_req}, 32'h0);
            end
            prev_req = bus_req;
        end
    end

    task automatic set_nop();
        mem_op = MEM_NOP; mem_addr = 32'h0; mem_data = 32'h0; mem_we = 1'b0;
        reg_we_in = 1'b0; reg_waddr_in = 5'h0; reg_wdata_in = 32'h0;
    endtask

    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] waddr, input int ack_at, input logic [31:0] rd,
                          input logic [31:0] x_addr, input logic [3:0] x_be, input logic x_we,
                          input logic [31:0] x_wdata, input logic x_rwe, input logic [31:0] x_rdata,
                          input logic x_err, input int x_cycles);
        ev_t e;
        bit  left;
        e = '{default: 0};
        e.kind = EV_BUS; e.addr = x_addr; e.be = x_be; e.we = x_we; e.wdata = x_wdata;
        exp_q.push_back(e);
        e = '{default: 0};
        e.kind = EV_DONE; e.reg_we = x_rwe; e.waddr = waddr; e.rdata = x_rdata;
        e.err = x_err; e.req_cycles = x_cycles;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_op = op; mem_addr = addr; mem_data = data; mem_we = x_we;
        reg_we_in = 1'b1; reg_waddr_in = waddr; reg_wdata_in = 32'h5555_AAAA;
        @(negedge clk);
        chk("idle_stall", {31'h0, stall}, 32'h1);
        chk("idle_reg_we", {31'h0, reg_we_out}, 32'h0);
        @(posedge clk); #1;
        set_nop();
        left = 1'b0;
        for (int c = 1; c <= int'(TO) + 4 && !left; c++) begin
            bus_ack = (c == ack_at);
            bus_rdata = (c == ack_at) ? rd : 32'h0;
            @(negedge clk);
            chk("req_stall", {31'h0, stall}, 32'h1);
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (!bus_req) left = 1'b1;
        end
        if (!left) begin
            checks++; failures++;
            $display("FAIL req_bound: bus_req still high after %0d cycles, expected release", TO + 4);
        end
        @(posedge clk);
    endtask

    task automatic misaligned_op(input logic [3:0] op, input logic [31:0] addr);
        ev_t e;
        e = '{default: 0};
        e.kind = EV_MIS;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_op = op; mem_addr = addr; mem_data = 32'h1234_5678; reg_we_in = 1'b1; reg_waddr_in = 5'd3;
        @(negedge clk);
        chk("mis_stall", {31'h0, stall}, 32'h0);
        chk("mis_reg_we", {31'h0, reg_we_out}, 32'h0);
        chk("mis_flag", {31'h0, misalign}, 32'h1);
        @(posedge clk); #1;
        set_nop();
        @(negedge clk);
        chk("mis_after_req", {31'h0, bus_req}, 32'h0);
        chk("mis_after_flag", {31'h0, misalign}, 32'h0);
    endtask

    task automatic all_zero(input string name);
        chk({name, "_req"}, {31'h0, bus_req}, 32'h0);
        chk({name, "_stall"}, {31'h0, stall}, 32'h0);
        chk({name, "_reg_we"}, {31'h0, reg_we_out}, 32'h0);
        chk({name, "_bus"}, {bus_addr[27:0], bus_be}, 32'h0);
        chk({name, "_wdata"}, bus_wdata | reg_wdata_out, 32'h0);
        chk({name, "_flags"}, {29'h0, bus_err, misalign, bus_we}, 32'h0);
    endtask

    initial begin
        ev_t e;
        set_nop();
        @(posedge clk); #1;
        @(negedge clk);
        all_zero("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        all_zero("post_reset");

        // NOP pass-through
        @(posedge clk); #1;
        reg_we_in = 1'b1; reg_waddr_in = 5'd7; reg_wdata_in = 32'hCAFE_F00D;
        @(negedge clk);
        chk("nop_we", {31'h0, reg_we_out}, 32'h1);
        chk("nop_waddr", {27'h0, reg_waddr_out}, 32'd7);
        chk("nop_wdata", reg_wdata_out, 32'hCAFE_F00D);
        chk("nop_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        set_nop();

        //     op   addr          data          wa  ack rd            xaddr         be       we    xwdata        rwe   xrdata        err   cyc
        access(SW,  32'h100, 32'hDEAD_BEEF, 5'd0,  1, 32'h0,        32'h100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 1);
        access(LB,  32'h203, 32'h0,         5'd5,  1, 32'h8011_2233, 32'h200, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 1);
        access(LBU, 32'h203, 32'h0,         5'd6,  1, 32'h8011_2233, 32'h200, 4'b1000, 1'b0, 32'h0,        1'b1, 32'h0000_0080, 1'b0, 1);
        access(SH,  32'h12,  32'h0000_ABCD, 5'd0,  1, 32'h0,        32'h10,  4'b1100, 1'b1, 32'hABCD_ABCD, 1'b0, 32'h0,        1'b0, 1);
        misaligned_op(LW, 32'h6);
        access(LW,  32'h400, 32'h0,         5'd8,  0, 32'h0,        32'h400, 4'b1111, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 4);
        access(LH,  32'h402, 32'h0,         5'd9,  2, 32'h8001_1234, 32'h400, 4'b1100, 1'b0, 32'h0,        1'b1, 32'hFFFF_8001, 1'b0, 2);
        access(LHU, 32'h400, 32'h0,         5'd10, 1, 32'h1234_F00D, 32'h400, 4'b0011, 1'b0, 32'h0,        1'b1, 32'h0000_F00D, 1'b0, 1);
        access(SB,  32'h501, 32'h0000_00A5, 5'd0,  1, 32'h0,        32'h500, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b0, 1);
        access(LW,  32'h600, 32'h0,         5'd31, 4, 32'h0BAD_F00D, 32'h600, 4'b1111, 1'b0, 32'h0,        1'b1, 32'h0BAD_F00D, 1'b0, 4);
        misaligned_op(LH, 32'h701);
        access(SH,  32'h702, 32'h0000_1234, 5'd0,  1, 32'h0,        32'h700, 4'b1100, 1'b1, 32'h1234_1234, 1'b0, 32'h0,        1'b0, 1);

        // Reset during REQ, late ack afterwards
        e = '{default: 0};
        e.kind = EV_BUS; e.addr = 32'h300; e.be = 4'b1111; e.we = 1'b0; e.wdata = 32'h0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_op = LW; mem_addr = 32'h300; reg_we_in = 1'b1; reg_waddr_in = 5'd4;
        @(posedge clk); #1;
        set_nop();
        @(negedge clk);
        chk("rst_pre_req", {31'h0, bus_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        all_zero("after_rst");
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        all_zero("late_ack");
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        all_zero("after_late_ack");

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
